// File: rtl/iic_cfg_sequencer.sv
// iic_cfg_sequencer: table-driven register-write sequencer in front of iic_master.
// The host fills a DEPTH-entry table of {reg_addr, data} pairs; on start the
// entries are issued in order as I2C writes to a fixed slave address, pacing
// on the master's ready handshake, with a timeout guarding every wait state.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for start_i; table writable
// LOAD       | register table[idx] onto the master's address/data inputs
// WAIT_RDY   | wait for the master to be idle
// REQ        | iic_flag_o high until the master drops ready (accepted)
// WAIT_DONE  | wait for the master to finish the transfer
// GAP        | idle spacing before the next entry, then advance idx
// FINISH     | one-cycle done_o pulse

module iic_cfg_sequencer #(
   parameter logic [6:0] SLV_ADDR   = 7'b1001011,
   parameter int         DEPTH      = 16,
   parameter int         GAP_CYCLES = 4,
   parameter int         TIMEOUT    = 4096,
   localparam int        AW         = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          cfg_we_i,
   input  logic [AW-1:0] cfg_addr_i,
   input  logic [15:0]   cfg_data_i,
   input  logic          start_i,
   input  logic [AW:0]   len_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [AW:0]   idx_o,
   input  logic          iic_ready_i,
   output logic          iic_flag_o,
   output logic [6:0]    iic_slv_addr_o,
   output logic [7:0]    iic_reg_addr_o,
   output logic [7:0]    iic_data_o
);

   // GAP always occupies at least one cycle, so GAP_CYCLES=0 and 1 behave alike.
   localparam int GAP_LD_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int GW         = $clog2(GAP_LD_INT + 2);
   localparam int TW         = $clog2(TIMEOUT + 1);

   localparam logic [GW-1:0] GAP_LD = GW'(GAP_LD_INT);
   localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_WAIT_RDY  = 3'd2,
      S_REQ       = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_GAP       = 3'd5,
      S_FINISH    = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   idx_q, idx_d;
   logic [AW:0]   len_q, len_d;
   logic          err_q, err_d;
   logic [7:0]    reg_addr_q;
   logic [7:0]    data_q;
   logic [TW-1:0] tmo_q;
   logic [GW-1:0] gap_q;
   logic [15:0]   tbl_q [DEPTH];

   logic [AW:0]   idx_inc;
   logic          tmo_tc;
   logic          gap_tc;
   logic          hs_enter;
   logic          gap_enter;

   function automatic logic is_hs(input state_t s);
      return (s == S_WAIT_RDY) || (s == S_REQ) || (s == S_WAIT_DONE);
   endfunction

   assign idx_inc   = idx_q + {{AW{1'b0}}, 1'b1};
   assign tmo_tc    = (tmo_q == '0);
   assign gap_tc    = (gap_q == '0);
   assign hs_enter  = is_hs(state_d) && (state_d != state_q);
   assign gap_enter = (state_d == S_GAP) && (state_q != S_GAP);

   // Configuration table; only writable while idle so a running sequence sees a frozen table.
   always_ff @(posedge clk_i) begin
      if (cfg_we_i && (state_q == S_IDLE)) begin
         tbl_q[cfg_addr_i] <= cfg_data_i;
      end
   end

   // State register and sequence bookkeeping.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   // Registered table read: the entry lands on the master inputs as LOAD exits.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         reg_addr_q <= '0;
         data_q     <= '0;
      end else if (state_q == S_LOAD) begin
         reg_addr_q <= tbl_q[idx_q[AW-1:0]][15:8];
         data_q     <= tbl_q[idx_q[AW-1:0]][7:0];
      end
   end

   // Handshake timeout: one down-counter reloaded on entry to each wait state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tmo_q <= '0;
      end else if (hs_enter) begin
         tmo_q <= TMO_LD;
      end else if (is_hs(state_q) && !tmo_tc) begin
         tmo_q <= tmo_q - TW'(1);
      end
   end

   // Inter-transfer gap down-counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         gap_q <= '0;
      end else if (gap_enter) begin
         gap_q <= GAP_LD;
      end else if ((state_q == S_GAP) && !gap_tc) begin
         gap_q <= gap_q - GW'(1);
      end
   end

   // Next-state logic; a real handshake event wins over a coincident timeout.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d = 1'b0;
               if (len_i != '0) begin
                  len_d   = len_i;
                  idx_d   = '0;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_LOAD: begin
            state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (iic_ready_i) begin
               state_d = S_REQ;
            end else if (tmo_tc) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (!iic_ready_i) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_tc) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (iic_ready_i) begin
               state_d = S_GAP;
            end else if (tmo_tc) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_tc) begin
               idx_d   = idx_inc;
               state_d = (idx_inc == len_q) ? S_FINISH : S_LOAD;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      busy_o     = (state_q != S_IDLE);
      done_o     = (state_q == S_FINISH);
      iic_flag_o = (state_q == S_REQ);
   end

   assign err_o          = err_q;
   assign idx_o          = idx_q;
   assign iic_slv_addr_o = SLV_ADDR;
   assign iic_reg_addr_o = reg_addr_q;
   assign iic_data_o     = data_q;

endmodule
